// File: rtl/input_capture_ctrl.sv
// input_capture_ctrl
// Hands switch words to the processor's IN instruction. The CPU raises req.
// The user sets the switches and presses the debounced button. Each rising
// edge of the button captures the switch word once. The word is offered with
// a valid/ack handshake, and stall holds the CPU until the word is delivered.
//
// Build option: define INPUT_TIMEOUT_EN to deliver TIMEOUT_VAL when nobody
// presses the button within TIMEOUT_CYCLES. If the macro is undefined, the
// block waits indefinitely and timed_out stays low. The port list is the
// same in both builds.
module input_capture_ctrl #(
  parameter int                 DATA_W         = 16,
  parameter int unsigned        TIMEOUT_CYCLES = 500_000_000,
  parameter logic [DATA_W-1:0]  TIMEOUT_VAL    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_db,
  input  logic [DATA_W-1:0] switches,
  input  logic              req,
  input  logic              ack,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              stall,
  output logic              wait_led,
  output logic              timed_out
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    HOLD         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t state;
  state_t next_state;
  logic   btn_prev;
  logic   rise;
  logic   timeout_hit;

  assign rise  = btn_db & ~btn_prev;
  assign stall = req & (state != HOLD);

`ifdef INPUT_TIMEOUT_EN
  logic [31:0] wait_cnt;

  assign timeout_hit = (state == WAIT_PRESS) && (wait_cnt == (TIMEOUT_CYCLES - 32'd1));

  // Count cycles spent in WAIT_PRESS. The count restarts at zero on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != WAIT_PRESS) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^{TIMEOUT_VAL, TIMEOUT_CYCLES};
`endif

  // Compute the next state. An abort from the CPU wins over a press, and a press wins over a timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) next_state = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!req) begin
          next_state = IDLE;
        end else if (rise || timeout_hit) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (ack || !req) next_state = btn_db ? WAIT_RELEASE : IDLE;
      end
      WAIT_RELEASE: begin
        if (!btn_db) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Update the state register, the edge-detect flop and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      btn_prev   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      wait_led   <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      btn_prev <= btn_db;
      state    <= next_state;
      wait_led <= (next_state == WAIT_PRESS);
      case (state)
        WAIT_PRESS: begin
          if (req) begin
            if (rise) begin
              data_out   <= switches;
              data_valid <= 1'b1;
              timed_out  <= 1'b0;
            end else if (timeout_hit) begin
              data_out   <= TIMEOUT_VAL;
              data_valid <= 1'b1;
              timed_out  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (ack || !req) begin
            data_valid <= 1'b0;
            timed_out  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_input_capture_ctrl.sv
// tb_input_capture_ctrl
// Directed bench for input_capture_ctrl. A scoreboard queue holds the words
// the CPU should receive. A monitor pops one entry each time data_valid rises.
// The timeout scenario runs only when INPUT_TIMEOUT_EN is defined.
module tb_input_capture_ctrl;

  logic        clk;
  logic        reset;
  logic        btn_db;
  logic [15:0] switches;
  logic        req;
  logic        ack;
  logic [15:0] data_out;
  logic        data_valid;
  logic        stall;
  logic        wait_led;
  logic        timed_out;

  typedef struct packed {
    logic [15:0] data;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_prev;

  input_capture_ctrl #(
    .DATA_W        (16),
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_VAL   (16'h00FF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_db    (btn_db),
    .switches  (switches),
    .req       (req),
    .ack       (ack),
    .data_out  (data_out),
    .data_valid(data_valid),
    .stall     (stall),
    .wait_led  (wait_led),
    .timed_out (timed_out)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive inputs on the falling edge, then return just after the next rising edge.
  task automatic applyStimulus(input logic r, input logic b, input logic [15:0] sw, input logic a);
    @(negedge clk);
    req      = r;
    btn_db   = b;
    switches = sw;
    ack      = a;
    @(posedge clk);
    #1;
  endtask

  task automatic expectWord(input logic [15:0] d, input logic t);
    exp_t e;
    e.data = d;
    e.to   = t;
    sb_q.push_back(e);
  endtask

  // Compare each new delivery against the oldest expected word.
  initial begin
    exp_t e;
    mon_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (data_valid && !mon_prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_delivery: got data %h, expected no delivery", data_out);
        end else begin
          e = sb_q.pop_front();
          checkOutput("sb_data", 32'(data_out), 32'(e.data));
          checkOutput("sb_timed_out", 32'(timed_out), 32'(e.to));
        end
      end
      mon_prev = data_valid;
    end
  end

  initial begin
    reset    = 1'b1;
    req      = 1'b0;
    btn_db   = 1'b0;
    switches = 16'h0000;
    ack      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_data_out", 32'(data_out), 32'h0);
    checkOutput("rst_data_valid", 32'(data_valid), 32'h0);
    checkOutput("rst_wait_led", 32'(wait_led), 32'h0);
    checkOutput("rst_timed_out", 32'(timed_out), 32'h0);
    checkOutput("rst_stall", 32'(stall), 32'h0);

    $display("[TB] basic IN");
    applyStimulus(1, 0, 16'hA5C3, 0);
    checkOutput("basic_wait_led", 32'(wait_led), 32'h1);
    checkOutput("basic_stall_wait", 32'(stall), 32'h1);
    applyStimulus(1, 0, 16'hA5C3, 0);
    expectWord(16'hA5C3, 1'b0);
    applyStimulus(1, 1, 16'hA5C3, 0);
    checkOutput("basic_valid_n1", 32'(data_valid), 32'h1);
    checkOutput("basic_data", 32'(data_out), 32'hA5C3);
    checkOutput("basic_stall_hold", 32'(stall), 32'h0);
    checkOutput("basic_led_hold", 32'(wait_led), 32'h0);
    applyStimulus(1, 1, 16'hA5C3, 1);
    checkOutput("basic_ack_valid", 32'(data_valid), 32'h0);
    checkOutput("basic_ack_stall", 32'(stall), 32'h1);
    applyStimulus(0, 0, 16'hA5C3, 0);
    checkOutput("basic_idle_stall", 32'(stall), 32'h0);

    $display("[TB] held button");
    applyStimulus(0, 1, 16'h1234, 0);
    applyStimulus(1, 1, 16'h1234, 0);
    checkOutput("held_wait_led", 32'(wait_led), 32'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 16'h1234, 0);
      checkOutput("held_no_capture", 32'(data_valid), 32'h0);
    end
    applyStimulus(1, 0, 16'h1234, 0);
    checkOutput("held_release_no_capture", 32'(data_valid), 32'h0);
    expectWord(16'h1234, 1'b0);
    applyStimulus(1, 1, 16'h1234, 0);
    checkOutput("held_capture", 32'(data_valid), 32'h1);
    applyStimulus(1, 1, 16'h1234, 1);
    applyStimulus(0, 1, 16'h1234, 0);
    applyStimulus(0, 0, 16'h1234, 0);

    $display("[TB] single press, two INs");
    applyStimulus(1, 0, 16'h0BEE, 0);
    expectWord(16'h0BEE, 1'b0);
    applyStimulus(1, 1, 16'h0BEE, 0);
    applyStimulus(1, 1, 16'hFFFF, 0);
    checkOutput("two_hold_stable", 32'(data_out), 32'h0BEE);
    applyStimulus(1, 1, 16'hFFFF, 1);
    checkOutput("two_ack_valid", 32'(data_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 16'hFFFF, 0);
      checkOutput("two_wrel_valid", 32'(data_valid), 32'h0);
      checkOutput("two_wrel_stall", 32'(stall), 32'h1);
      checkOutput("two_wrel_led", 32'(wait_led), 32'h0);
    end
    applyStimulus(1, 0, 16'h5A5A, 0);
    checkOutput("two_idle_stall", 32'(stall), 32'h1);
    checkOutput("two_idle_led", 32'(wait_led), 32'h0);
    applyStimulus(1, 0, 16'h5A5A, 0);
    checkOutput("two_wp_led", 32'(wait_led), 32'h1);
    expectWord(16'h5A5A, 1'b0);
    applyStimulus(1, 1, 16'h5A5A, 0);
    checkOutput("two_second_data", 32'(data_out), 32'h5A5A);
    applyStimulus(1, 1, 16'h5A5A, 1);
    applyStimulus(0, 0, 16'h5A5A, 0);

    $display("[TB] abort");
    applyStimulus(1, 0, 16'h7777, 0);
    applyStimulus(0, 0, 16'h7777, 0);
    checkOutput("abort_led", 32'(wait_led), 32'h0);
    checkOutput("abort_valid", 32'(data_valid), 32'h0);
    applyStimulus(0, 1, 16'h7777, 0);
    checkOutput("abort_idle_rise", 32'(data_valid), 32'h0);
    applyStimulus(0, 0, 16'h7777, 0);
    applyStimulus(1, 0, 16'h6666, 0);
    applyStimulus(0, 1, 16'h6666, 0);
    checkOutput("abort_beats_rise", 32'(data_valid), 32'h0);
    applyStimulus(0, 0, 16'h6666, 0);

    $display("[TB] reset mid-HOLD");
    applyStimulus(1, 0, 16'hC0DE, 0);
    expectWord(16'hC0DE, 1'b0);
    applyStimulus(1, 1, 16'hC0DE, 0);
    checkOutput("rst_pre_valid", 32'(data_valid), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rstm_valid", 32'(data_valid), 32'h0);
    checkOutput("rstm_data", 32'(data_out), 32'h0);
    checkOutput("rstm_led", 32'(wait_led), 32'h0);
    checkOutput("rstm_stall", 32'(stall), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 1, 16'hC0DE, 0);
    checkOutput("rstm_after_led", 32'(wait_led), 32'h1);
    checkOutput("rstm_after_valid", 32'(data_valid), 32'h0);
    applyStimulus(0, 0, 16'hC0DE, 0);

`ifdef INPUT_TIMEOUT_EN
    $display("[TB] timeout");
    applyStimulus(1, 0, 16'h4321, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 0, 16'h4321, 0);
      checkOutput("to_not_yet", 32'(data_valid), 32'h0);
    end
    expectWord(16'h00FF, 1'b1);
    applyStimulus(1, 0, 16'h4321, 0);
    checkOutput("to_valid", 32'(data_valid), 32'h1);
    checkOutput("to_flag", 32'(timed_out), 32'h1);
    checkOutput("to_data", 32'(data_out), 32'h00FF);
    applyStimulus(0, 0, 16'h4321, 1);
    checkOutput("to_flag_clr", 32'(timed_out), 32'h0);
    applyStimulus(1, 0, 16'hBEEF, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 16'hBEEF, 0);
    expectWord(16'hBEEF, 1'b0);
    applyStimulus(1, 1, 16'hBEEF, 0);
    checkOutput("to_race_flag", 32'(timed_out), 32'h0);
    applyStimulus(0, 1, 16'hBEEF, 1);
    applyStimulus(0, 0, 16'hBEEF, 0);
`else
    $display("[TB] no timeout in default build");
    applyStimulus(1, 0, 16'h4321, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 16'h4321, 0);
    checkOutput("nto_valid", 32'(data_valid), 32'h0);
    checkOutput("nto_led", 32'(wait_led), 32'h1);
    checkOutput("nto_flag", 32'(timed_out), 32'h0);
    applyStimulus(0, 0, 16'h4321, 0);
`endif

    repeat (3) applyStimulus(0, 0, 16'h0000, 0);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
